rc5_round_sched: RTL

Round scheduler and arbiter for the shared RC5 round datapath and its S-table. Two requesters, an encrypt client and a decrypt client, submit (A,B) blocks. The block arbitrates between them round-robin and loads the winner into the datapath. It then walks the S-table address pairs in the correct order for the mode, and captures the result into a single output buffer with a valid/ready handshake. It holds no arithmetic; it owns sequencing, S-table addressing and result buffering.

---
 rtl/rc5_round_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rc5_round_sched.sv
// rtl/rc5_round_sched.sv - round scheduler, arbiter and result buffer for the shared RC5 datapath
//
// Ports:
//   clk                       single clock, rising edge
//   rst                       synchronous reset, active low
//   enc_req/enc_A/enc_B       encrypt requester: request held with block words until enc_gnt
//   dec_req/dec_A/dec_B       decrypt requester: request held with block words until dec_gnt
//   enc_gnt/dec_gnt           one-cycle grant pulse to the winning requester
//   dp_load/dp_A_in/dp_B_in   load the granted block into the datapath registers
//   dp_mode                   0 = encrypt, 1 = decrypt, stable for the whole block
//   dp_step/dp_k              perform step dp_k with the S words now on the table output
//   S_addr_a/S_addr_b         S-table addresses 2k/2k+1 of the step being prefetched
//   dp_A_out/dp_B_out         datapath register outputs, captured in DRAIN
//   res_valid/res_ready       result buffer handshake
//   res_mode/res_A/res_B      buffered result
//   busy                      high whenever the scheduler is not IDLE
module rc5_round_sched #(
    parameter int r        = 12,
    parameter int w        = 32,
    parameter int t_length = $clog2(2*r+2),
    parameter int k_length = $clog2(r+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enc_req,
    input  logic [w-1:0]        enc_A,
    input  logic [w-1:0]        enc_B,
    input  logic                dec_req,
    input  logic [w-1:0]        dec_A,
    input  logic [w-1:0]        dec_B,
    output logic                enc_gnt,
    output logic                dec_gnt,
    output logic                dp_load,
    output logic [w-1:0]        dp_A_in,
    output logic [w-1:0]        dp_B_in,
    output logic                dp_mode,
    output logic                dp_step,
    output logic [k_length-1:0] dp_k,
    output logic [t_length-1:0] S_addr_a,
    output logic [t_length-1:0] S_addr_b,
    input  logic [w-1:0]        dp_A_out,
    input  logic [w-1:0]        dp_B_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_mode,
    output logic [w-1:0]        res_A,
    output logic [w-1:0]        res_B,
    output logic                busy
);

    // Counts the steps still to be issued for the current block (r+1 per block).
    localparam int c_length = $clog2(r+2);
    localparam logic [k_length-1:0] k_last = k_length'(r);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    state_t                state;
    logic                  last_served;   // 1 = decrypt served last
    logic [k_length-1:0]   addr_k;        // step whose S words are currently addressed
    logic [c_length-1:0]   steps_left;
    logic                  pick_dec;
    logic [k_length-1:0]   first_k;
    logic [k_length-1:0]   k_adv;

    function automatic logic [t_length-1:0] even_addr(input logic [k_length-1:0] k);
        return t_length'({k, 1'b0});
    endfunction

    function automatic logic [t_length-1:0] odd_addr(input logic [k_length-1:0] k);
        return t_length'({k, 1'b1});
    endfunction

    // Round-robin: a lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        pick_dec = dec_req;
        if (enc_req && dec_req) begin
            pick_dec = ~last_served;
        end
    end

    assign first_k = pick_dec ? k_last : '0;
    assign k_adv   = dp_mode ? (addr_k - 1'b1) : (addr_k + 1'b1);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            addr_k      <= '0;
            steps_left  <= '0;
            enc_gnt     <= 1'b0;
            dec_gnt     <= 1'b0;
            dp_load     <= 1'b0;
            dp_A_in     <= '0;
            dp_B_in     <= '0;
            dp_mode     <= 1'b0;
            dp_step     <= 1'b0;
            dp_k        <= '0;
            S_addr_a    <= '0;
            S_addr_b    <= '0;
            res_valid   <= 1'b0;
            res_mode    <= 1'b0;
            res_A       <= '0;
            res_B       <= '0;
        end else begin
            enc_gnt <= 1'b0;
            dec_gnt <= 1'b0;
            dp_load <= 1'b0;
            dp_step <= 1'b0;
            case (state)
                IDLE: begin
                    if (enc_req || dec_req) begin
                        state       <= RUN;
                        last_served <= pick_dec;
                        enc_gnt     <= ~pick_dec;
                        dec_gnt     <= pick_dec;
                        dp_load     <= 1'b1;
                        dp_mode     <= pick_dec;
                        dp_A_in     <= pick_dec ? dec_A : enc_A;
                        dp_B_in     <= pick_dec ? dec_B : enc_B;
                        addr_k      <= first_k;
                        S_addr_a    <= even_addr(first_k);
                        S_addr_b    <= odd_addr(first_k);
                        steps_left  <= c_length'(r + 1);
                    end
                end
                RUN: begin
                    // The table has one cycle of read latency, so the step issued now
                    // uses the address presented last cycle while the next is prefetched.
                    if (steps_left != '0) begin
                        dp_step    <= 1'b1;
                        dp_k       <= addr_k;
                        steps_left <= steps_left - 1'b1;
                        // The final step leaves the address parked on its own words.
                        if (steps_left != c_length'(1)) begin
                            addr_k   <= k_adv;
                            S_addr_a <= even_addr(k_adv);
                            S_addr_b <= odd_addr(k_adv);
                        end
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    res_A     <= dp_A_out;
                    res_B     <= dp_B_out;
                    res_mode  <= dp_mode;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
